id_exe_stage: RTL and testbench

//  ID->EXE pipeline register with load-use hazard detection and bubble insertion.

---
 rtl/id_exe_stage.sv | 147 ++++++++++++++
 tb/tb_id_exe_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register with load-use hazard detection and bubble insertion.
// Optional feature: define HAZARD_STATS_EN to add the hz_stall_count stall counter port.
module id_exe_stage #(
  parameter int DATA_W       = 32,
  parameter int CTRL_W       = 8,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_reg_rs,
  input  logic [4:0]        id_reg_rt,
  input  logic [4:0]        id_reg_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              exe_valid,
  output logic [4:0]        exe_reg_rs,
  output logic [4:0]        exe_reg_rt,
  output logic [4:0]        exe_reg_rd,
  output logic [DATA_W-1:0] exe_rs_data,
  output logic [DATA_W-1:0] exe_rt_data,
  output logic [DATA_W-1:0] exe_imm,
  output logic              exe_reg_write,
  output logic              exe_mem_read,
  output logic              exe_mem_write,
  output logic [CTRL_W-1:0] exe_ctrl,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       hz_stall_count,
`endif
  output logic              stall_if_id
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic       w_hazard;
  logic       w_bubble;

  // Only a valid load in EXE writing a non-zero register can block the ID instruction.
  assign w_hazard = id_valid & exe_valid & exe_mem_read & (exe_reg_rd != 5'd0) &
                    ((exe_reg_rd == id_reg_rs) | (id_uses_rt & (exe_reg_rd == id_reg_rt)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard && (STALL_CYCLES > 1)) begin
            w_state_nxt = STALL;
            w_cnt_nxt   = 2'(STALL_CYCLES - 1);
          end
        end
        STALL: begin
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // In STALL the EXE slot holds a bubble, so w_hazard is already 0 there.
  always_comb begin
    w_bubble    = flush | (r_state == STALL) | w_hazard;
    stall_if_id = en & ~flush & ((r_state == STALL) | w_hazard);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      exe_valid     <= 1'b0;
      exe_reg_rs    <= 5'd0;
      exe_reg_rt    <= 5'd0;
      exe_reg_rd    <= 5'd0;
      exe_rs_data   <= '0;
      exe_rt_data   <= '0;
      exe_imm       <= '0;
      exe_reg_write <= 1'b0;
      exe_mem_read  <= 1'b0;
      exe_mem_write <= 1'b0;
      exe_ctrl      <= '0;
    end else if (en) begin
      if (w_bubble) begin
        exe_valid     <= 1'b0;
        exe_reg_rs    <= 5'd0;
        exe_reg_rt    <= 5'd0;
        exe_reg_rd    <= 5'd0;
        exe_rs_data   <= '0;
        exe_rt_data   <= '0;
        exe_imm       <= '0;
        exe_reg_write <= 1'b0;
        exe_mem_read  <= 1'b0;
        exe_mem_write <= 1'b0;
        exe_ctrl      <= '0;
      end else begin
        // An invalid ID slot still moves its fields, but must carry no side effects.
        exe_valid     <= id_valid;
        exe_reg_rs    <= id_reg_rs;
        exe_reg_rt    <= id_reg_rt;
        exe_reg_rd    <= id_reg_rd;
        exe_rs_data   <= id_rs_data;
        exe_rt_data   <= id_rt_data;
        exe_imm       <= id_imm;
        exe_reg_write <= id_valid & id_reg_write;
        exe_mem_read  <= id_valid & id_mem_read;
        exe_mem_write <= id_valid & id_mem_write;
        exe_ctrl      <= id_valid ? id_ctrl : '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // stall_if_id already implies en=1, so the counter holds whenever en=0.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hz_stall_count <= 32'd0;
    end else if (stall_if_id && (hz_stall_count != 32'hFFFF_FFFF)) begin
      hz_stall_count <= hz_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Randomized bench for id_exe_stage: one instance with STALL_CYCLES=1 and one with 3,
// both driven by the same ID stream and compared against a bubble-budget reference model.
module tb_id_exe_stage;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        rw, mr, mw;
    logic [7:0]  ctrl;
  } exe_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en, flush, id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rsd, id_rtd, id_imm;
  logic        id_rw, id_mr, id_mw;
  logic [7:0]  id_ctrl;

  logic        ex_v[2], ex_rw[2], ex_mr[2], ex_mw[2], stall[2];
  logic [4:0]  ex_rs[2], ex_rt[2], ex_rd[2];
  logic [31:0] ex_rsd[2], ex_rtd[2], ex_imm[2];
  logic [7:0]  ex_ctrl[2];
  logic [31:0] hz_cnt[2];

  int   total = 0;
  int   bad = 0;
  exe_t m_exe[2];
  int   m_pend[2];
  logic [31:0] m_hz[2];
  int   obs_stalls[2];
  int   sc[2] = '{1, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_exe_stage #(.DATA_W(32), .CTRL_W(8), .STALL_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .arst_n(arst_n), .en(en), .flush(flush), .id_valid(id_valid),
      .id_reg_rs(id_rs), .id_reg_rt(id_rt), .id_reg_rd(id_rd), .id_uses_rt(id_uses_rt),
      .id_rs_data(id_rsd), .id_rt_data(id_rtd), .id_imm(id_imm),
      .id_reg_write(id_rw), .id_mem_read(id_mr), .id_mem_write(id_mw), .id_ctrl(id_ctrl),
      .exe_valid(ex_v[g]), .exe_reg_rs(ex_rs[g]), .exe_reg_rt(ex_rt[g]), .exe_reg_rd(ex_rd[g]),
      .exe_rs_data(ex_rsd[g]), .exe_rt_data(ex_rtd[g]), .exe_imm(ex_imm[g]),
      .exe_reg_write(ex_rw[g]), .exe_mem_read(ex_mr[g]), .exe_mem_write(ex_mw[g]),
      .exe_ctrl(ex_ctrl[g]),
`ifdef HAZARD_STATS_EN
      .hz_stall_count(hz_cnt[g]),
`endif
      .stall_if_id(stall[g])
    );
`ifndef HAZARD_STATS_EN
    assign hz_cnt[g] = 32'd0;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_exe[k]  = '0;
      m_pend[k] = 0;
      m_hz[k]   = 32'd0;
    end
  endtask

  function automatic logic model_hazard(input int k);
    exe_t e = m_exe[k];
    return id_valid && e.v && e.mr && (e.rd != 5'd0) &&
           ((e.rd == id_rs) || (id_uses_rt && (e.rd == id_rt)));
  endfunction

  task automatic cmp_out();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("valid%0d", k), 32'(ex_v[k]),    32'(m_exe[k].v));
      check($sformatf("rs%0d", k),    32'(ex_rs[k]),   32'(m_exe[k].rs));
      check($sformatf("rt%0d", k),    32'(ex_rt[k]),   32'(m_exe[k].rt));
      check($sformatf("rd%0d", k),    32'(ex_rd[k]),   32'(m_exe[k].rd));
      check($sformatf("rsd%0d", k),   ex_rsd[k],       m_exe[k].rsd);
      check($sformatf("rtd%0d", k),   ex_rtd[k],       m_exe[k].rtd);
      check($sformatf("imm%0d", k),   ex_imm[k],       m_exe[k].imm);
      check($sformatf("rw%0d", k),    32'(ex_rw[k]),   32'(m_exe[k].rw));
      check($sformatf("mr%0d", k),    32'(ex_mr[k]),   32'(m_exe[k].mr));
      check($sformatf("mw%0d", k),    32'(ex_mw[k]),   32'(m_exe[k].mw));
      check($sformatf("ctrl%0d", k),  32'(ex_ctrl[k]), 32'(m_exe[k].ctrl));
`ifdef HAZARD_STATS_EN
      check($sformatf("hzcnt%0d", k), hz_cnt[k], m_hz[k]);
`endif
    end
  endtask

  // Called at a negedge after inputs are set; returns at the following negedge.
  task automatic cycle();
    exe_t nxt[2];
    int   pend_n[2];
    logic st;
    #1;
    for (int k = 0; k < 2; k++) begin
      st = en && !flush && ((m_pend[k] > 0) || model_hazard(k));
      check($sformatf("stall%0d", k), 32'(stall[k]), 32'(st));
      if (stall[k] === 1'b1) obs_stalls[k]++;
      nxt[k] = m_exe[k];
      pend_n[k] = m_pend[k];
      if (en) begin
        if (flush) begin
          nxt[k] = '0; pend_n[k] = 0;
        end else if (m_pend[k] > 0) begin
          nxt[k] = '0; pend_n[k] = m_pend[k] - 1;
        end else if (model_hazard(k)) begin
          nxt[k] = '0; pend_n[k] = sc[k] - 1;
        end else begin
          nxt[k] = '{v: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                     rsd: id_rsd, rtd: id_rtd, imm: id_imm,
                     rw: id_valid & id_rw, mr: id_valid & id_mr, mw: id_valid & id_mw,
                     ctrl: id_valid ? id_ctrl : 8'd0};
        end
        if (st && m_hz[k] != 32'hFFFF_FFFF) m_hz[k] = m_hz[k] + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_exe[k]  = nxt[k];
      m_pend[k] = pend_n[k];
    end
    cmp_out();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt; id_mr = mr;
    id_rw = mr | $urandom_range(0, 1); id_mw = ~mr & $urandom_range(0, 1);
    id_rsd = $urandom; id_rtd = $urandom; id_imm = $urandom; id_ctrl = 8'($urandom);
  endtask

  task automatic async_reset();
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    cmp_out();
    check("rst_stall0", 32'(stall[0]), 32'd0);
    check("rst_stall1", 32'(stall[1]), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0; en = 1'b1; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    cmp_out();
    arst_n = 1'b1;

    // Load-use: lw r5 then add rs=5; S=1 stalls once, S=3 stalls three times.
    obs_stalls = '{0, 0};
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    repeat (5) cycle();
    check("lu_stalls_s1", 32'(obs_stalls[0]), 32'd1);
    check("lu_stalls_s3", 32'(obs_stalls[1]), 32'd3);
    check("lu_rd_s1", 32'(ex_rd[0]), 32'd7);
    check("lu_rd_s3", 32'(ex_rd[1]), 32'd7);

    // Load to r0 and an rt-only match without id_uses_rt never stall.
    obs_stalls = '{0, 0};
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); cycle();
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b0, 1'b0); cycle();
    check("nostall_s1", 32'(obs_stalls[0]), 32'd0);
    check("nostall_s3", 32'(obs_stalls[1]), 32'd0);

    // Flush during the second stall cycle.
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd9, 5'd5, 5'd8, 1'b1, 1'b0); cycle();
    flush = 1'b1; cycle();
    check("flush_stall_s3", 32'(obs_stalls[1]), 32'd1);
    flush = 1'b0; repeat (2) cycle();

    // en=0 for four cycles in the middle of a stall, then resume.
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd6, 5'd0, 5'd9, 1'b0, 1'b0); cycle();
    en = 1'b0; repeat (4) cycle();
    en = 1'b1; repeat (3) cycle();

    // Async reset in the middle of a stall.
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1); cycle();
    set_id(1'b1, 5'd4, 5'd0, 5'd9, 1'b0, 1'b0); cycle();
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 11) == 0);
      set_id($urandom_range(0, 6) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
